rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: RR_ENABLE, default 1, 1 = round-robin arbitration, 0 = fixed priority with req[0] highest.
REQ-002 Reset is rst, asynchronous, active-high; clock is clk.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req  input  3  write request per requester (0 = ALU, 1 = load unit, 2 = debug/immediate).
REQ-006 addr0, addr1, addr2  input  2 each  target register (R0..R3) for requester 0/1/2.
REQ-007 data0, data1, data2  input  8 each  write data for requester 0/1/2.
REQ-008 hold  input  1  1 = suppress all grants this cycle.
REQ-009 gnt  output  3  one-hot grant, combinational, same cycle as accepted req.
REQ-010 reg_write  output  1  registered register-file write enable.
REQ-011 write_reg  output  2  registered register-file write address.
REQ-012 write_data  output  8  registered register-file write data.
REQ-013 pend_mask  output  4  bit k = 1 when any asserted req targets Rk and is not granted this cycle.

Function
REQ-014 Handshake SHALL be valid/ready: a transfer occurs in the cycle where req[i]=1 and gnt[i]=1; requester holds req[i], addr i, data i stable until then.
REQ-015 gnt SHALL have at most one bit set, SHALL satisfy gnt[i] -> req[i], and SHALL be 0 whenever hold=1 or rst=1.
REQ-016 With hold=0 and req!=0, exactly one grant SHALL issue every cycle (work-conserving).
REQ-017 RR_ENABLE=1: 2-bit pointer ptr in {0,1,2}; search order ptr, ptr+1, ptr+2 (mod 3); first requesting index wins.
REQ-018 RR_ENABLE=1: after a grant to index i, ptr SHALL become (i+1) mod 3; ptr unchanged in cycles with no grant.
REQ-019 RR_ENABLE=0: winner is lowest-index requester; ptr unused and held at 0.
REQ-020 Latency: transfer in cycle N SHALL produce reg_write=1, write_reg=addr_i, write_data=data_i during cycle N+1, exactly one cycle.
REQ-021 In any cycle with no transfer, the next cycle SHALL have reg_write=0; write_reg/write_data hold their previous values.
REQ-022 Same-address contention: two requesters targeting the same register in one cycle SHALL be served in arbitration order in consecutive grants; both writes reach the output, the later grant lands last.
REQ-023 A requester dropping req before grant SHALL be permitted; no write and no ptr change results for it.
REQ-024 pend_mask SHALL be combinational: OR over i of (req[i] & ~gnt[i]) decoded on addr i.
REQ-025 ptr value 3 SHALL never occur; if reached, it SHALL be treated as 0.

Reset
REQ-026 While rst=1: reg_write=0, write_reg=0, write_data=8'h00, ptr=0, gnt=0, asynchronously, regardless of clk.
REQ-027 A transfer in the cycle rst asserts SHALL be discarded; no reg_write pulse follows reset release.
REQ-028 First cycle after rst deassertion, arbitration SHALL start from ptr=0.

Verification
REQ-029 Single request: req=3'b010, addr1=2, data1=8'hA5 -> gnt=3'b010 same cycle; next cycle reg_write=1, write_reg=2, write_data=8'hA5; ptr=2.
REQ-030 Round-robin fairness: req=3'b111 held 6 cycles from reset -> gnt sequence 001,010,100,001,010,100; six consecutive reg_write pulses.
REQ-031 Fixed priority (RR_ENABLE=0): req=3'b110 for 2 cycles, req[2] kept after its partner is served -> gnt 010 then 100.
REQ-032 Same-address contention: req0 addr0=3 data0=8'h11, req2 addr2=3 data2=8'h22, ptr=0 -> writes R3=8'h11 then R3=8'h22 on consecutive cycles; pend_mask=4'b1000 in first cycle, 4'b0000 in second.
REQ-033 Hold: req=3'b001 with hold=1 for 3 cycles -> gnt=0, reg_write=0, pend_mask=4'b0001 per addr0=0; hold drop -> grant same cycle, write next cycle.
REQ-034 Reset mid-operation: rst asserted asynchronously while reg_write=1 -> reg_write, write_reg, write_data clear before next clk edge; after release req=3'b100 granted with ptr starting at 0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Three-requester register-file write arbiter: round-robin or fixed-priority
// grant, one-cycle registered write port, and a per-register pending mask.
module rf_write_arbiter #(
    parameter int RR_ENABLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [1:0] addr0,
    input  logic [1:0] addr1,
    input  logic [1:0] addr2,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic       hold,
    output logic [2:0] gnt,
    output logic       reg_write,
    output logic [1:0] write_reg,
    output logic [7:0] write_data,
    output logic [3:0] pend_mask
);

    logic [2:0][1:0] addr_a;
    logic [2:0][7:0] data_a;

    logic [1:0] ptr_q, ptr_d, ptr_eff;
    logic       reg_write_q, reg_write_d;
    logic [1:0] write_reg_q, write_reg_d;
    logic [7:0] write_data_q, write_data_d;

    logic [2:0] req_act, rot_req, rot_sel, gnt_c;
    logic [5:0] req_dbl, sel_dbl;

    assign addr_a = {addr2, addr1, addr0};
    assign data_a = {data2, data1, data0};

    // Rotate requests so the pointer index sits at bit 0, pick the lowest
    // set bit, then rotate the one-hot pick back into requester order.
    always_comb begin
        ptr_eff = (RR_ENABLE != 0 && ptr_q != 2'd3) ? ptr_q : 2'd0;
        req_act = hold ? 3'b000 : req;
        req_dbl = {req_act, req_act} >> ptr_eff;
        rot_req = req_dbl[2:0];
        rot_sel = 3'b000;
        if (rot_req[0])      rot_sel = 3'b001;
        else if (rot_req[1]) rot_sel = 3'b010;
        else if (rot_req[2]) rot_sel = 3'b100;
        sel_dbl = {3'b000, rot_sel} << ptr_eff;
        gnt_c   = sel_dbl[2:0] | sel_dbl[5:3];
    end

    // Reset gating stays on the output only, keeping rst out of the flop data path.
    assign gnt = rst ? 3'b000 : gnt_c;

    always_comb begin
        reg_write_d  = |gnt_c;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        ptr_d        = ptr_eff;
        for (int i = 0; i < 3; i++) begin
            if (gnt_c[i]) begin
                write_reg_d  = addr_a[i];
                write_data_d = data_a[i];
                if (RR_ENABLE != 0) ptr_d = (i == 2) ? 2'd0 : 2'(i + 1);
            end
        end
    end

    always_comb begin
        pend_mask = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            if (req[i] && !gnt[i]) pend_mask[addr_a[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= 2'd0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= 2'd0;
            write_data_q <= 8'h00;
        end else begin
            ptr_q        <= ptr_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign reg_write  = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a round-robin instance checked through
// a write scoreboard, plus a fixed-priority instance checked on its grants.
module tb_rf_write_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hold = 1'b0;
    logic [2:0] req = 3'b000;
    logic [1:0] addr0 = 2'd0, addr1 = 2'd0, addr2 = 2'd0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00, data2 = 8'h00;

    logic [2:0] gnt, gnt_fp;
    logic       reg_write, reg_write_fp;
    logic [1:0] write_reg, write_reg_fp;
    logic [7:0] write_data, write_data_fp;
    logic [3:0] pend_mask, pend_mask_fp;

    typedef struct packed {
        logic       we;
        logic [1:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t sb[$];
    wr_t last_wr;
    int  vectors = 0;
    int  miscompares = 0;

    rf_write_arbiter #(.RR_ENABLE(1)) dut (
        .clk(clk), .rst(rst), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .data0(data0), .data1(data1), .data2(data2),
        .hold(hold), .gnt(gnt), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data), .pend_mask(pend_mask)
    );

    rf_write_arbiter #(.RR_ENABLE(0)) dut_fp (
        .clk(clk), .rst(rst), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .data0(data0), .data1(data1), .data2(data2),
        .hold(hold), .gnt(gnt_fp), .reg_write(reg_write_fp),
        .write_reg(write_reg_fp), .write_data(write_data_fp), .pend_mask(pend_mask_fp)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] fp_model(input logic [2:0] r, input logic h, input logic rs);
        if (h || rs)   return 3'b000;
        if (r[0])      return 3'b001;
        if (r[1])      return 3'b010;
        if (r[2])      return 3'b100;
        return 3'b000;
    endfunction

    // Inputs are set 1 time unit after a rising edge; combinational outputs
    // are sampled mid-cycle, the write port 1 unit after the next edge.
    task automatic step(input logic [2:0] eg, input logic [3:0] ep);
        wr_t e;
        #3;
        chk("gnt", 8'(gnt), 8'(eg));
        chk("pend_mask", 8'(pend_mask), 8'(ep));
        chk("gnt_fp", 8'(gnt_fp), 8'(fp_model(req, hold, rst)));
        e.we = 1'b0; e.a = last_wr.a; e.d = last_wr.d;
        if (eg[0])      begin e.we = 1'b1; e.a = addr0; e.d = data0; end
        else if (eg[1]) begin e.we = 1'b1; e.a = addr1; e.d = data1; end
        else if (eg[2]) begin e.we = 1'b1; e.a = addr2; e.d = data2; end
        if (e.we) last_wr = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("reg_write", 8'(reg_write), 8'(e.we));
        chk("write_reg", 8'(write_reg), 8'(e.a));
        chk("write_data", write_data, e.d);
    endtask

    initial begin
        addr0 = 2'd0; addr1 = 2'd1; addr2 = 2'd2;
        req = 3'b111;
        #1 rst = 1'b1;
        #1;
        chk("rst_gnt", 8'(gnt), 8'h00);
        chk("rst_gnt_fp", 8'(gnt_fp), 8'h00);
        chk("rst_reg_write", 8'(reg_write), 8'h00);
        chk("rst_write_reg", 8'(write_reg), 8'h00);
        chk("rst_write_data", write_data, 8'h00);
        chk("rst_pend_mask", 8'(pend_mask), 8'h07);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        req = 3'b000;
        last_wr = '0;

        // Round-robin rotation with all three requesting.
        for (int k = 0; k < 6; k++) begin
            logic [2:0] eg;
            req = 3'b111;
            data0 = 8'(8'h10 + k); data1 = 8'(8'h20 + k); data2 = 8'(8'h30 + k);
            eg = 3'b001 << (k % 3);
            step(eg, {1'b0, ~eg});
        end

        // Single request from the load unit, then confirm the pointer moved to 2.
        req = 3'b010; addr1 = 2'd2; data1 = 8'hA5;
        step(3'b010, 4'b0000);
        addr1 = 2'd1; req = 3'b111;
        step(3'b100, 4'b0011);
        req = 3'b000;
        step(3'b000, 4'b0000);

        // Two requesters hitting R3 in the same cycle.
        req = 3'b101; addr0 = 2'd3; data0 = 8'h11; addr2 = 2'd3; data2 = 8'h22;
        step(3'b001, 4'b1000);
        req = 3'b100;
        step(3'b100, 4'b0000);

        // Hold suppresses grants, release grants in the same cycle.
        req = 3'b001; addr0 = 2'd0; data0 = 8'h5C; addr2 = 2'd2; hold = 1'b1;
        repeat (3) step(3'b000, 4'b0001);
        hold = 1'b0;
        step(3'b001, 4'b0000);
        req = 3'b000;
        step(3'b000, 4'b0000);

        // ptr is 1: req0 loses, then drops without a write or pointer change.
        req = 3'b011; data1 = 8'h61;
        step(3'b010, 4'b0001);
        req = 3'b000;
        step(3'b000, 4'b0000);
        req = 3'b111; data2 = 8'h62;
        step(3'b100, 4'b0011);

        // req 110 then 100: both instances grant 010 then 100.
        req = 3'b110; data1 = 8'h71; data2 = 8'h72;
        step(3'b010, 4'b0100);
        req = 3'b100;
        step(3'b100, 4'b0000);

        // Asynchronous reset while the write port is active.
        req = 3'b010; data1 = 8'h77;
        step(3'b010, 4'b0000);
        #1 rst = 1'b1;
        #1;
        chk("arst_reg_write", 8'(reg_write), 8'h00);
        chk("arst_write_reg", 8'(write_reg), 8'h00);
        chk("arst_write_data", write_data, 8'h00);
        chk("arst_gnt", 8'(gnt), 8'h00);
        req = 3'b111;
        @(posedge clk);
        #1 rst = 1'b0;
        req = 3'b000;
        last_wr = '0;
        step(3'b000, 4'b0000);
        req = 3'b111;
        step(3'b001, 4'b0110);
        req = 3'b100; data2 = 8'h99;
        step(3'b100, 4'b0000);
        req = 3'b000;
        step(3'b000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
